// File: rtl/slow_div.sv
// slow_div - iterative restoring divider, one quotient bit per clock.
//
// An accepted start captures the operands; W clock edges later the quotient,
// remainder and divide-by-zero flag load together and valid pulses for one
// cycle. The handshake matches the shift-add slow multiplier, so both can sit
// behind the same start/busy/valid control.
//
// Parameters:
//   W            operand width (dividend, divisor, quotient, remainder), W >= 2
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset, discards any in-flight operation
//   dividend     numerator, sampled only on an accepted start
//   divisor      denominator, sampled only on an accepted start
//   start        request, accepted only while busy=0
//   quotient     registered quotient, holds until the next completion
//   remainder    registered remainder, holds until the next completion
//   div_by_zero  registered flag, set when the captured divisor was zero
//   valid        one-cycle pulse: results were updated this cycle
//   busy         high while an operation is in progress
//
// Build option:
//   SLOW_DIV_SIGNED_EN  when defined, operands are two's complement; the
//                       quotient truncates toward zero and the remainder takes
//                       the sign of the dividend. Undefined: unsigned only.

module slow_div #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic         start,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         valid,
    output logic         busy
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_next;

    logic [W-1:0]  quo_sh;
    logic [W-1:0]  dvs;
    logic [W:0]    prem;
    logic [CW-1:0] cnt;
    logic          dvs_zero;

    logic          load;
    logic          done;

    logic [W:0]    shifted;
    logic [W:0]    trial;
    logic [W:0]    prem_next;
    logic [W-1:0]  quo_next;
    logic [W-1:0]  quo_fin;
    logic [W-1:0]  rem_fin;

    logic [W-1:0]  cap_dividend;
    logic [W-1:0]  cap_divisor;

`ifdef SLOW_DIV_SIGNED_EN
    logic sign_q;
    logic sign_r;

    // Operands enter the array as magnitudes; the signs are applied at the end.
    always_comb begin
        cap_dividend = dividend[W-1] ? (~dividend + W'(1)) : dividend;
        cap_divisor  = divisor[W-1]  ? (~divisor  + W'(1)) : divisor;
    end
`else
    always_comb begin
        cap_dividend = dividend;
        cap_divisor  = divisor;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (cnt == LAST_STEP) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One restoring step. The partial remainder stays below the divisor, so
    // the W+1-bit shifted value never overflows and bit W of the trial
    // difference is a reliable sign bit.
    always_comb begin
        shifted = {prem[W-1:0], quo_sh[W-1]};
        trial   = shifted - {1'b0, dvs};
        if (!trial[W]) begin
            prem_next = trial;
            quo_next  = {quo_sh[W-2:0], 1'b1};
        end else begin
            prem_next = shifted;
            quo_next  = {quo_sh[W-2:0], 1'b0};
        end
    end

`ifdef SLOW_DIV_SIGNED_EN
    // Divide by zero keeps the raw all-ones quotient; the remainder correction
    // still runs, which turns |dividend| back into the raw dividend.
    always_comb begin
        quo_fin = (sign_q && !dvs_zero) ? (~quo_next + W'(1)) : quo_next;
        rem_fin = sign_r ? (~prem_next[W-1:0] + W'(1)) : prem_next[W-1:0];
    end
`else
    always_comb begin
        quo_fin = quo_next;
        rem_fin = prem_next[W-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_sh   <= '0;
            dvs      <= '0;
            prem     <= '0;
            cnt      <= '0;
            dvs_zero <= 1'b0;
        end else if (load) begin
            quo_sh   <= cap_dividend;
            dvs      <= cap_divisor;
            prem     <= '0;
            cnt      <= '0;
            dvs_zero <= (divisor == '0);
        end else if (state == RUN) begin
            quo_sh   <= quo_next;
            prem     <= prem_next;
            cnt      <= cnt + CW'(1);
        end
    end

`ifdef SLOW_DIV_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            sign_r <= 1'b0;
        end else if (load) begin
            sign_q <= dividend[W-1] ^ divisor[W-1];
            sign_r <= dividend[W-1];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            valid       <= 1'b0;
        end else begin
            valid <= done;
            if (done) begin
                quotient    <= quo_fin;
                remainder   <= rem_fin;
                div_by_zero <= dvs_zero;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_slow_div.sv
// tb_slow_div - directed and random self-checking bench for slow_div (W=16).

module tb_slow_div;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         start;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         valid;
    logic         busy;

    int tests_run;
    int tests_failed;

    slow_div #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dividend    (dividend),
        .divisor     (divisor),
        .start       (start),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .valid       (valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request starting at the current time (caller is at a negedge),
    // then watches negedges until valid. lat is the number of rising edges from
    // the accepting edge to the edge that raised valid (-1 on timeout).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cycles);
        int n;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        busy_cycles = 0;
        lat = -1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (busy) busy_cycles++;
            if (valid) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        #23;
        tests_run++;
        if ({busy, valid, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: busy=%0b valid=%0b dbz=%0b q=%h r=%h, want all 0",
                     busy, valid, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bc;
        @(negedge clk);
        run_op(16'd100, 16'd7, lat, bc);
        tests_run++;
        if (lat !== 16 || bc !== 16) begin
            tests_failed++;
            $display("[TB] FAIL basic_latency: lat=%0d busy_cycles=%0d, want 16/16", lat, bc);
        end
        tests_run++;
        if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_100_7: q=%0d r=%0d dbz=%0b, want 14 2 0",
                     quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        tests_run++;
        if (valid !== 1'b0 || quotient !== 16'd14) begin
            tests_failed++;
            $display("[TB] FAIL valid_pulse_hold: valid=%0b q=%0d, want 0 14", valid, quotient);
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic [W-1:0] vq [4];
        logic [W-1:0] vr [4];
        int lat, bc;
        va = '{16'hFFFF, 16'd5, 16'd0, 16'hFFFF};
        vb = '{16'd1,    16'd9, 16'd3, 16'hFFFF};
        vq = '{16'hFFFF, 16'd0, 16'd0, 16'd1};
        vr = '{16'd0,    16'd5, 16'd0, 16'd0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run_op(va[i], vb[i], lat, bc);
            tests_run++;
            if (lat !== 16 || quotient !== vq[i] || remainder !== vr[i] || div_by_zero !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL boundary_%0d (%h/%h): lat=%0d q=%h r=%h dbz=%0b, want lat=16 q=%h r=%h dbz=0",
                         i, va[i], vb[i], lat, quotient, remainder, div_by_zero, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        @(negedge clk);
        run_op(16'd1234, 16'd0, lat, bc);
        tests_run++;
        if (lat !== 16 || quotient !== 16'hFFFF || remainder !== 16'd1234 || div_by_zero !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL div_by_zero: lat=%0d q=%h r=%0d dbz=%0b, want 16 ffff 1234 1",
                     lat, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        run_op(16'd8, 16'd2, lat, bc);
        tests_run++;
        if (quotient !== 16'd4 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL after_dbz_8_2: q=%0d r=%0d dbz=%0b, want 4 0 0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_ignore_start();
        int n;
        logic got;
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        dividend = 16'd9;
        divisor  = 16'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        got = 1'b0;
        n = 6;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (valid) got = 1'b1;
        end
        tests_run++;
        if (!got || n !== 17 || quotient !== 16'd14 || remainder !== 16'd2) begin
            tests_failed++;
            $display("[TB] FAIL ignore_start: seen=%0b cycle=%0d q=%0d r=%0d, want 1 17 14 2",
                     got, n, quotient, remainder);
        end
    endtask

    // Called while sitting in the valid cycle of the previous operation.
    task automatic test_back_to_back();
        int lat, bc;
        run_op(16'd9, 16'd3, lat, bc);
        tests_run++;
        if (lat !== 16 || bc !== 16 || quotient !== 16'd3 || remainder !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back: lat=%0d busy_cycles=%0d q=%0d r=%0d, want 16 16 3 0",
                     lat, bc, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || valid !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_op: busy=%0b valid=%0b q=%h r=%h, want 0 0 0 0",
                     busy, valid, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (valid || busy) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("[TB] FAIL no_valid_after_reset: active cycles=%0d, want 0", seen);
        end
    endtask

`ifdef SLOW_DIV_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic [W-1:0] vq [3];
        logic [W-1:0] vr [3];
        int lat, bc;
        va = '{16'hFFF9, 16'd7,    16'h8000};
        vb = '{16'd2,    16'hFFFE, 16'hFFFF};
        vq = '{16'hFFFD, 16'hFFFD, 16'h8000};
        vr = '{16'hFFFF, 16'd1,    16'd0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            run_op(va[i], vb[i], lat, bc);
            tests_run++;
            if (lat !== 16 || quotient !== vq[i] || remainder !== vr[i]) begin
                tests_failed++;
                $display("[TB] FAIL signed_%0d (%h/%h): lat=%0d q=%h r=%h, want 16 q=%h r=%h",
                         i, va[i], vb[i], lat, quotient, remainder, vq[i], vr[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] a, b, eq, er;
        int lat, bc;
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
`ifdef SLOW_DIV_SIGNED_EN
            a[W-1] = 1'b0;
            b[W-1] = 1'b0;
`endif
            if (i % 4 == 0) b = b >> $urandom_range(1, 14);
            if (b == '0) b = 16'd1;
            eq = a / b;
            er = a % b;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(a, b, lat, bc);
            tests_run++;
            if (lat !== 16 || bc !== 16 || quotient !== eq || remainder !== er || div_by_zero !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d (%h/%h): lat=%0d busy=%0d q=%h r=%h, want 16 16 q=%h r=%h",
                         i, a, b, lat, bc, quotient, remainder, eq, er);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_by_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
`ifdef SLOW_DIV_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
